// File: rtl/compress_word_packer.sv
// Output packing stage: concatenates MSB-aligned variable-length fragments into
// 128-bit lines, emitting full lines and a zero-padded tail line on flush.
module compress_word_packer #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic [LEN_WIDTH-1:0]  o_bits,
    output logic                  o_last
);

    localparam int unsigned FILL_W = LEN_WIDTH + 1;
    localparam int unsigned ACC_W  = 2 * DATA_WIDTH;
    localparam logic [LEN_WIDTH-1:0] FULL_LEN  = LEN_WIDTH'(DATA_WIDTH);
    localparam logic [FILL_W-1:0]    FULL_FILL = FILL_W'(DATA_WIDTH);

    typedef enum logic [1:0] {StAccum, StEmit, StTail} state_e;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic                flush_pend_q, flush_pend_d;

    logic                accept;
    logic [LEN_WIDTH-1:0] len_sat;
    logic [FILL_W-1:0]   fill_sum;
    logic [FILL_W-1:0]   fill_rem;
    logic [ACC_W-1:0]    shifted;

    // Over-length fragments are a protocol violation; clamp rather than corrupt fill.
    assign len_sat  = (i_len > FULL_LEN) ? FULL_LEN : i_len;
    assign fill_sum = fill_q + {1'b0, len_sat};
    assign fill_rem = fill_q - FULL_FILL;
    assign shifted  = {i_data, {DATA_WIDTH{1'b0}}} >> fill_q;
    assign accept   = i_valid && (state_q == StAccum);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StAccum: begin
                if (accept) begin
                    if (fill_sum >= FULL_FILL) begin
                        state_d = StEmit;
                    end else if (i_flush) begin
                        state_d = StTail;
                    end
                end
            end
            StEmit: begin
                if (i_ready) begin
                    if (flush_pend_q && (fill_rem != '0)) begin
                        state_d = StTail;
                    end else begin
                        state_d = StAccum;
                    end
                end
            end
            StTail: begin
                if (i_ready) begin
                    state_d = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // Datapath next-state
    always_comb begin
        acc_d        = acc_q;
        fill_d       = fill_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            StAccum: begin
                if (accept) begin
                    acc_d        = acc_q | shifted;
                    fill_d       = fill_sum;
                    flush_pend_d = i_flush;
                end
            end
            StEmit: begin
                if (i_ready) begin
                    acc_d  = acc_q << DATA_WIDTH;
                    fill_d = fill_rem;
                    if (fill_rem == '0) begin
                        flush_pend_d = 1'b0;
                    end
                end
            end
            StTail: begin
                if (i_ready) begin
                    acc_d        = '0;
                    fill_d       = '0;
                    flush_pend_d = 1'b0;
                end
            end
            default: begin
                acc_d        = '0;
                fill_d       = '0;
                flush_pend_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q        <= '0;
            fill_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Outputs come from registered state; reset only forces them quiet.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_word  = '0;
        o_bits  = '0;
        o_last  = 1'b0;
        if (!i_rst) begin
            case (state_q)
                StAccum: begin
                    o_ready = 1'b1;
                end
                StEmit: begin
                    o_valid = 1'b1;
                    o_word  = acc_q[ACC_W-1:DATA_WIDTH];
                    o_bits  = FULL_LEN;
                    o_last  = flush_pend_q && (fill_q == FULL_FILL);
                end
                StTail: begin
                    o_valid = 1'b1;
                    o_word  = acc_q[ACC_W-1:DATA_WIDTH];
                    o_bits  = fill_q[LEN_WIDTH-1:0];
                    o_last  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_compress_word_packer.sv
// Directed self-checking bench for compress_word_packer.
module tb_compress_word_packer;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] i_data;
    logic [7:0]   i_len;
    logic         i_flush;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_word;
    logic [7:0]   o_bits;
    logic         o_last;

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    compress_word_packer #(
        .DATA_WIDTH(128),
        .LEN_WIDTH (8)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
        .i_len  (i_len),
        .i_flush(i_flush),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_word (o_word),
        .o_bits (o_bits),
        .o_last (o_last)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present one fragment and hold it until accepted (bounded wait).
    task automatic send(input logic [127:0] d, input logic [7:0] l, input logic f);
        int n = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_len   = l;
        i_flush = f;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        chk("send_ready", {127'b0, o_ready}, 128'd1);
        tick();
        i_valid = 1'b0;
        i_data  = '0;
        i_len   = '0;
        i_flush = 1'b0;
    endtask

    task automatic expect_line(input string tag, input logic [127:0] w, input logic [7:0] b,
                               input logic l);
        chk({tag, "_valid"}, {127'b0, o_valid}, 128'd1);
        chk({tag, "_word"}, o_word, w);
        chk({tag, "_bits"}, {120'b0, o_bits}, {120'b0, b});
        chk({tag, "_last"}, {127'b0, o_last}, {127'b0, l});
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_idle_valid"}, {127'b0, o_valid}, 128'd0);
        chk({tag, "_idle_ready"}, {127'b0, o_ready}, 128'd1);
    endtask

    initial begin
        logic [127:0] ones100;
        logic [127:0] ones68;
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_len   = '0;
        i_flush = 1'b0;
        i_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", {127'b0, o_valid}, 128'd0);
        chk("rst_ready", {127'b0, o_ready}, 128'd0);
        chk("rst_word", o_word, 128'd0);
        chk("rst_bits", {120'b0, o_bits}, 128'd0);
        chk("rst_last", {127'b0, o_last}, 128'd0);
        i_rst = 1'b0;
        #1;
        expect_idle("post_rst");

        // Four 32-bit fragments make one full line
        send({32'hAAAAAAAA, 96'b0}, 8'd32, 1'b0);
        send({32'hBBBBBBBB, 96'b0}, 8'd32, 1'b0);
        send({32'hCCCCCCCC, 96'b0}, 8'd32, 1'b0);
        chk("t1_pre_valid", {127'b0, o_valid}, 128'd0);
        send({32'hDDDDDDDD, 96'b0}, 8'd32, 1'b0);
        chk("t1_emit_ready", {127'b0, o_ready}, 128'd0);
        expect_line("t1", 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, 8'd128, 1'b0);
        expect_idle("t1");

        // 100 ones + 60-bit fragment + flush-only beat
        ones100 = ~128'b0 << 28;
        send(ones100, 8'd100, 1'b0);
        send({60'h0123456789ABCDE, 68'b0}, 8'd60, 1'b0);
        expect_line("t2a", {ones100[127:28], 28'h0123456}, 8'd128, 1'b0);
        expect_idle("t2a");
        send('0, 8'd0, 1'b1);
        expect_line("t2b", {32'h789ABCDE, 96'b0}, 8'd32, 1'b1);
        expect_idle("t2b");

        // Single 128-bit fragment with flush: exactly one line
        send(128'h11223344_55667788_99AABBCC_DDEEFF00, 8'd128, 1'b1);
        expect_line("t3", 128'h11223344_55667788_99AABBCC_DDEEFF00, 8'd128, 1'b1);
        expect_idle("t3");
        tick();
        tick();
        chk("t3_no_tail", {127'b0, o_valid}, 128'd0);

        // Flush-only on empty packer
        send('0, 8'd0, 1'b1);
        expect_line("t4", 128'd0, 8'd0, 1'b1);
        expect_idle("t4");

        // Over-length i_len saturates to 128
        send(128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, 8'd200, 1'b1);
        expect_line("sat", 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978, 8'd128, 1'b1);
        expect_idle("sat");

        // Backpressure: line held stable for 5 stalled cycles
        send(128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF, 8'd128, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {127'b0, o_valid}, 128'd1);
            chk("bp_ready", {127'b0, o_ready}, 128'd0);
            chk("bp_word", o_word, 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF);
            chk("bp_bits", {120'b0, o_bits}, 128'd128);
            tick();
        end
        expect_line("bp", 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF, 8'd128, 1'b0);
        expect_idle("bp");

        // Reset while in EMIT with 40 residual bits
        ones68 = ~128'b0 << 60;
        send(ones100, 8'd100, 1'b0);
        send(ones68, 8'd68, 1'b0);
        chk("t6_in_emit", {127'b0, o_valid}, 128'd1);
        i_rst = 1'b1;
        #1;
        chk("t6_rst_valid", {127'b0, o_valid}, 128'd0);
        chk("t6_rst_ready", {127'b0, o_ready}, 128'd0);
        chk("t6_rst_word", o_word, 128'd0);
        tick();
        i_rst = 1'b0;
        #1;
        expect_idle("t6_post");
        send(128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 8'd128, 1'b1);
        expect_line("t6", 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 8'd128, 1'b1);
        expect_idle("t6");
        tick();
        chk("t6_no_tail", {127'b0, o_valid}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
